alu_arbiter: RTL and testbench

//  Shares one combinational 4-bit Alu (A,B,sel -> res) between two requesters.

---
 rtl/alu_arbiter_if.sv | 49 ++++
 rtl/alu_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Handshake and Alu bus shared by alu_arbiter and its two requesters.
// The slave modport is the arbiter's view; the master modport is the requester/Alu side.
interface alu_arbiter_if #(
   parameter int W     = 4,
   parameter int SEL_W = 4
);
   logic             req0_valid;
   logic             req0_ready;
   logic [W-1:0]     req0_a;
   logic [W-1:0]     req0_b;
   logic [SEL_W-1:0] req0_sel;
   logic             req1_valid;
   logic             req1_ready;
   logic [W-1:0]     req1_a;
   logic [W-1:0]     req1_b;
   logic [SEL_W-1:0] req1_sel;
   logic             rsp0_valid;
   logic             rsp0_ready;
   logic [W-1:0]     rsp0_res;
   logic             rsp0_err;
   logic             rsp1_valid;
   logic             rsp1_ready;
   logic [W-1:0]     rsp1_res;
   logic             rsp1_err;
   logic [W-1:0]     alu_a;
   logic [W-1:0]     alu_b;
   logic [SEL_W-1:0] alu_sel;
   logic [W-1:0]     alu_res;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_sel,
      input  req1_valid, req1_a, req1_b, req1_sel,
      input  rsp0_ready, rsp1_ready, alu_res,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp0_res, rsp0_err,
      output rsp1_valid, rsp1_res, rsp1_err,
      output alu_a, alu_b, alu_sel
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_sel,
      output req1_valid, req1_a, req1_b, req1_sel,
      output rsp0_ready, rsp1_ready, alu_res,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp0_res, rsp0_err,
      input  rsp1_valid, rsp1_res, rsp1_err,
      input  alu_a, alu_b, alu_sel
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one combinational Alu; one transaction in flight.
// Define ALU_ARB_RR_EN for round-robin tie-breaking, otherwise requester 0 has fixed priority.
module alu_arbiter #(
   parameter int W       = 4,
   parameter int SEL_W   = 4,
   parameter int NUM_OPS = 13
) (
   input  logic          clk,
   input  logic          rst,
   alu_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;

   state_t           r_state;
   state_t           w_next;
   logic             r_grant;
   logic             w_gnt0;
   logic             w_gnt1;
   logic             w_accept;
   logic             w_rsp_done;
   logic [W-1:0]     r_alu_a_p0;
   logic [W-1:0]     r_alu_b_p0;
   logic [SEL_W-1:0] r_alu_sel_p0;
   logic [W-1:0]     r_res0_p1;
   logic [W-1:0]     r_res1_p1;
   logic             r_err0_p1;
   logic             r_err1_p1;
   logic             r_vld0_p1;
   logic             r_vld1_p1;
`ifdef ALU_ARB_RR_EN
   logic             r_last_grant;
`endif

   function automatic logic f_illegal(input logic [SEL_W-1:0] sel);
      return {1'b0, sel} >= (SEL_W + 1)'(NUM_OPS);
   endfunction

   function automatic logic [W-1:0] f_capture(input logic [W-1:0] res, input logic [SEL_W-1:0] sel);
      return f_illegal(sel) ? '0 : res;
   endfunction

   // Grant is combinational from valid, so ready may only rise in IDLE.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (r_state == S_IDLE) begin
`ifdef ALU_ARB_RR_EN
         if (bus.req0_valid && bus.req1_valid) begin
            w_gnt0 = r_last_grant;
            w_gnt1 = !r_last_grant;
         end else begin
            w_gnt0 = bus.req0_valid;
            w_gnt1 = bus.req1_valid;
         end
`else
         w_gnt0 = bus.req0_valid;
         w_gnt1 = bus.req1_valid && !bus.req0_valid;
`endif
      end
   end

   assign w_accept   = w_gnt0 || w_gnt1;
   assign w_rsp_done = r_grant ? (r_vld1_p1 && bus.rsp1_ready) : (r_vld0_p1 && bus.rsp0_ready);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_EXEC;
         S_EXEC:  w_next = S_RESP;
         S_RESP:  if (w_rsp_done) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Stage p0: operands latched on accept and held for the Alu.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alu_a_p0   <= '0;
         r_alu_b_p0   <= '0;
         r_alu_sel_p0 <= '0;
         r_grant      <= 1'b0;
`ifdef ALU_ARB_RR_EN
         r_last_grant <= 1'b1;
`endif
      end else if (w_accept) begin
         r_alu_a_p0   <= w_gnt1 ? bus.req1_a   : bus.req0_a;
         r_alu_b_p0   <= w_gnt1 ? bus.req1_b   : bus.req0_b;
         r_alu_sel_p0 <= w_gnt1 ? bus.req1_sel : bus.req0_sel;
         r_grant      <= w_gnt1;
`ifdef ALU_ARB_RR_EN
         r_last_grant <= w_gnt1;
`endif
      end
   end

   // Stage p1: Alu result captured leaving EXEC, held until the response handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_res0_p1 <= '0;
         r_res1_p1 <= '0;
         r_err0_p1 <= 1'b0;
         r_err1_p1 <= 1'b0;
         r_vld0_p1 <= 1'b0;
         r_vld1_p1 <= 1'b0;
      end else if (r_state == S_EXEC) begin
         if (r_grant) begin
            r_res1_p1 <= f_capture(bus.alu_res, r_alu_sel_p0);
            r_err1_p1 <= f_illegal(r_alu_sel_p0);
            r_vld1_p1 <= 1'b1;
         end else begin
            r_res0_p1 <= f_capture(bus.alu_res, r_alu_sel_p0);
            r_err0_p1 <= f_illegal(r_alu_sel_p0);
            r_vld0_p1 <= 1'b1;
         end
      end else if (w_rsp_done) begin
         if (r_grant) begin
            r_vld1_p1 <= 1'b0;
            r_err1_p1 <= 1'b0;
         end else begin
            r_vld0_p1 <= 1'b0;
            r_err0_p1 <= 1'b0;
         end
      end
   end

   assign bus.req0_ready = w_gnt0;
   assign bus.req1_ready = w_gnt1;
   assign bus.rsp0_valid = r_vld0_p1;
   assign bus.rsp0_res   = r_res0_p1;
   assign bus.rsp0_err   = r_err0_p1;
   assign bus.rsp1_valid = r_vld1_p1;
   assign bus.rsp1_res   = r_res1_p1;
   assign bus.rsp1_err   = r_err1_p1;
   assign bus.alu_a      = r_alu_a_p0;
   assign bus.alu_b      = r_alu_b_p0;
   assign bus.alu_sel    = r_alu_sel_p0;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with the Alu stubbed as a ^ b.
// Expected grants/results come from a small model (last grant, per-requester held result).
module tb_alu_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_arbiter_if bus ();
   alu_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
   assign bus.alu_res = bus.alu_a ^ bus.alu_b;

   int         total = 0;
   int         bad   = 0;
   bit         m_last;
   logic [3:0] m_res [2];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] ref_res(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
      return (s < 13) ? (a ^ b) : 4'h0;
   endfunction

   function automatic logic rspv(input int who);
      return (who == 1) ? bus.rsp1_valid : bus.rsp0_valid;
   endfunction
   function automatic logic [3:0] rspres(input int who);
      return (who == 1) ? bus.rsp1_res : bus.rsp0_res;
   endfunction
   function automatic logic rsperr(input int who);
      return (who == 1) ? bus.rsp1_err : bus.rsp0_err;
   endfunction

   task automatic set_req(input int who, input logic v, input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
      if (who == 0) begin
         bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_sel = s;
      end else begin
         bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_sel = s;
      end
   endtask

   // Called just after a negedge; returns at negedge+1 with a ready visible.
   task automatic wait_grant(input int exp_who, input string tag);
      for (int i = 0; i < 20; i++) begin
         #1;
         if (bus.req0_ready || bus.req1_ready) break;
         @(negedge clk);
      end
      chk({tag, "_ready0"}, bus.req0_ready, (exp_who == 0) ? 8'd1 : 8'd0);
      chk({tag, "_ready1"}, bus.req1_ready, (exp_who == 1) ? 8'd1 : 8'd0);
      m_last = exp_who[0];
   endtask

   // From just after the accept-cycle ready check through the first RESP negedge.
   task automatic finish_txn(input int who, input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                             input bit keep, input string tag);
      logic [3:0] exp;
      exp = ref_res(a, b, s);
      @(posedge clk);
      @(negedge clk);
      if (!keep) set_req(who, 1'b0, a, b, s);
      chk({tag, "_alu_a"}, bus.alu_a, a);
      chk({tag, "_alu_b"}, bus.alu_b, b);
      chk({tag, "_alu_sel"}, bus.alu_sel, s);
      chk({tag, "_early_vld"}, rspv(who), 8'd0);
      @(negedge clk);
      chk({tag, "_vld"}, rspv(who), 8'd1);
      chk({tag, "_res"}, rspres(who), exp);
      chk({tag, "_err"}, rsperr(who), (s >= 13) ? 8'd1 : 8'd0);
      chk({tag, "_other_vld"}, rspv(1 - who), 8'd0);
      chk({tag, "_other_res"}, rspres(1 - who), m_res[1 - who]);
      m_res[who] = exp;
   endtask

   task automatic release_chk(input int who, input string tag);
      @(negedge clk);
      chk({tag, "_rel_vld"}, rspv(who), 8'd0);
      chk({tag, "_rel_err"}, rsperr(who), 8'd0);
      chk({tag, "_rel_res"}, rspres(who), m_res[who]);
   endtask

   initial begin
      logic [3:0] a, b, s;
      logic [3:0] a1, b1, s1;
      int         who;
      int         exp_who;

      set_req(0, 1'b0, 4'h0, 4'h0, 4'h0);
      set_req(1, 1'b0, 4'h0, 4'h0, 4'h0);
      bus.rsp0_ready = 1'b1;
      bus.rsp1_ready = 1'b1;
      m_last   = 1'b1;
      m_res[0] = 4'h0;
      m_res[1] = 4'h0;

      #12;
      chk("rst_rsp0_vld", bus.rsp0_valid, 8'd0);
      chk("rst_rsp1_vld", bus.rsp1_valid, 8'd0);
      chk("rst_alu_a", bus.alu_a, 8'd0);
      chk("rst_alu_sel", bus.alu_sel, 8'd0);
      chk("rst_rsp0_res", bus.rsp0_res, 8'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Directed: basic op on requester 0
      set_req(0, 1'b1, 4'h4, 4'h6, 4'h0);
      wait_grant(0, "t1");
      finish_txn(0, 4'h4, 4'h6, 4'h0, 1'b0, "t1");
      chk("t1_res_const", bus.rsp0_res, 8'h2);
      release_chk(0, "t1");

      // Directed: illegal selector on requester 1
      set_req(1, 1'b1, 4'h3, 4'h5, 4'hD);
      wait_grant(1, "t2");
      finish_txn(1, 4'h3, 4'h5, 4'hD, 1'b0, "t2");
      release_chk(1, "t2");

      // Randomized single-requester traffic
      for (int n = 0; n < 16; n++) begin
         who = $urandom_range(0, 1);
         a   = 4'($urandom_range(0, 15));
         b   = 4'($urandom_range(0, 15));
         s   = 4'($urandom_range(0, 15));
         set_req(who, 1'b1, a, b, s);
         wait_grant(who, "rnd");
         finish_txn(who, a, b, s, 1'b0, "rnd");
         release_chk(who, "rnd");
      end

      // Both requesters valid continuously
      a  = 4'($urandom_range(0, 15)); b  = 4'($urandom_range(0, 15)); s  = 4'($urandom_range(0, 12));
      a1 = 4'($urandom_range(0, 15)); b1 = 4'($urandom_range(0, 15)); s1 = 4'($urandom_range(0, 12));
      set_req(0, 1'b1, a, b, s);
      set_req(1, 1'b1, a1, b1, s1);
      for (int n = 0; n < 4; n++) begin
`ifdef ALU_ARB_RR_EN
         exp_who = m_last ? 0 : 1;
`else
         exp_who = 0;
`endif
         wait_grant(exp_who, "both");
         if (exp_who == 0) finish_txn(0, a, b, s, 1'b1, "both");
         else              finish_txn(1, a1, b1, s1, 1'b1, "both");
         release_chk(exp_who, "both");
      end
      set_req(0, 1'b0, a, b, s);
      set_req(1, 1'b0, a1, b1, s1);
      @(negedge clk);

      // Response back-pressure blocks the other requester
      bus.rsp0_ready = 1'b0;
      a = 4'h9; b = 4'h3; s = 4'h5;
      set_req(0, 1'b1, a, b, s);
      wait_grant(0, "bp");
      @(posedge clk);
      @(negedge clk);
      set_req(0, 1'b0, a, b, s);
      set_req(1, 1'b1, 4'hA, 4'h5, 4'h1);
      #1;
      chk("bp_exec_ready1", bus.req1_ready, 8'd0);
      @(negedge clk);
      m_res[0] = ref_res(a, b, s);
      for (int n = 0; n < 5; n++) begin
         chk("bp_hold_vld", bus.rsp0_valid, 8'd1);
         chk("bp_hold_res", bus.rsp0_res, m_res[0]);
         chk("bp_hold_ready1", bus.req1_ready, 8'd0);
         @(negedge clk);
      end
      bus.rsp0_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_after_vld", bus.rsp0_valid, 8'd0);
      chk("bp_after_ready1", bus.req1_ready, 8'd1);
      m_last = 1'b1;
      finish_txn(1, 4'hA, 4'h5, 4'h1, 1'b0, "bp1");
      release_chk(1, "bp1");

      // Asynchronous reset in the middle of EXEC
      set_req(0, 1'b1, 4'hF, 4'h1, 4'h2);
      wait_grant(0, "ar");
      @(posedge clk);
      @(negedge clk);
      set_req(0, 1'b0, 4'hF, 4'h1, 4'h2);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_alu_a", bus.alu_a, 8'd0);
      chk("ar_alu_b", bus.alu_b, 8'd0);
      chk("ar_alu_sel", bus.alu_sel, 8'd0);
      chk("ar_rsp0_res", bus.rsp0_res, 8'd0);
      chk("ar_rsp1_res", bus.rsp1_res, 8'd0);
      chk("ar_rsp0_vld", bus.rsp0_valid, 8'd0);
      chk("ar_rsp1_err", bus.rsp1_err, 8'd0);
      m_last   = 1'b1;
      m_res[0] = 4'h0;
      m_res[1] = 4'h0;
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 2; n++) begin
         @(negedge clk);
         chk("ar_no_rsp0", bus.rsp0_valid, 8'd0);
         chk("ar_no_rsp1", bus.rsp1_valid, 8'd0);
      end
      set_req(0, 1'b1, 4'h7, 4'h2, 4'h3);
      set_req(1, 1'b1, 4'h1, 4'h8, 4'h4);
      wait_grant(0, "ar_first");
      finish_txn(0, 4'h7, 4'h2, 4'h3, 1'b0, "ar_first");
      set_req(1, 1'b0, 4'h1, 4'h8, 4'h4);
      release_chk(0, "ar_first");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
